uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares one byte-wide UART transmitter among three byte-stream requesters.
- Arbitrates round-robin, holds the grant for a packet (up to a burst limit), and presents one byte at a time to the transmitter with a start pulse.
- Tracks the transmitter's busy handshake.
- Sits between message sources (banner, status, echo) and the uart_tx datapath inside the tomkeddie top.

Parameters:
- MAX_BURST, 4: max bytes sent per grant before a forced rotation; range 1..15.
- ACK_TIMEOUT, 8: cycles to wait for tx_busy to rise after tx_start before declaring a fault; range 2..255.

Ports:
- clk  input  1  system clock (io_in[0] at top level).
- reset  input  1  synchronous, active-high reset.
- req_valid  input  3  per-requester byte available.
- req_data  input  24  requester i byte on bits [8i+7:8i].
- req_last  input  3  byte on req_data is the final byte of its packet.
- req_ready  output  3  one-hot accept strobe; a byte transfers when req_valid[i] & req_ready[i].
- grant  output  3  one-hot current owner; 0 when idle.
- tx_data  output  8  byte presented to the transmitter, held stable from the start pulse until release.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_busy  input  1  transmitter busy (high while shifting a frame).
- timeout_err  output  1  sticky fault flag; cleared only by reset.

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - state=IDLE; grant=0, req_ready=0, tx_start=0, tx_data=0x00, timeout_err=0.
  - Priority pointer=0, burst counter=0, timeout counter=0.
  - A reset mid-frame abandons the byte. No further tx_start until a new arbitration.
- States: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from the pointer upward, wrapping 2→0.
  - grant<=onehot(winner), burst<=0, go to LOAD. Otherwise stay.
- LOAD:
  - req_ready[g]=req_valid[g], combinational, only this state.
  - On transfer: tx_data<=req_data[g], last_q<=req_last[g], burst<=burst+1, go to START.
  - If req_valid[g] is low, stay in LOAD with the grant held; the packet lock is never broken by other requesters.
- START: tx_start=1 for exactly this one cycle; timeout counter<=0; go to WAIT_ACK.
- WAIT_ACK:
  - tx_busy=1 → WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT-1, set timeout_err<=1 and treat the byte as done (go directly to the release decision below).
- WAIT_DONE: wait until tx_busy=0, then apply the release decision.
- Release decision:
  - If last_q=1 or burst==MAX_BURST: grant<=0, pointer<=(g+1) mod 3, go to IDLE.
  - Otherwise go to LOAD with the same grant.
  - After a forced rotation the requester keeps its pending bytes and re-arbitrates normally.
- Latency:
  - req_valid high in IDLE at cycle N → req_ready at N+1 → tx_start at N+2.
  - Back-to-back bytes in one packet: tx_start again 2 cycles after tx_busy falls.
- Simultaneous events:
  - A requester dropping req_valid in the same cycle it is granted is not an error; LOAD simply waits.
  - req_valid changes during WAIT_* are ignored.
- tx_data changes only on a LOAD transfer or reset.
- At most one bit of req_ready and of grant is ever set.

Test Plan:
- Single requester: req 1 sends 0x48, 0x69 (last on 0x69); model tx_busy high for 10 cycles, one cycle after each tx_start → exactly two tx_start pulses with tx_data=0x48 then 0x69; grant=3'b010 throughout, then 0; pointer=2.
- Contention: all three valid from reset, single-byte packets 0xA0/0xB1/0xC2 → transmit order 0xA0, 0xB1, 0xC2; grant 001→010→100.
- Burst limit: MAX_BURST=4; req 0 offers 6 bytes 0x10..0x15 (last on 0x15); req 2 has a single byte 0x77 pending → order 0x10–0x13, 0x77, 0x14, 0x15.
- Packet lock: req 0 granted, drops req_valid for 20 cycles mid-packet while req 1 is valid → no tx_start and grant stays 001 until req 0 resumes.
- Timeout: tx_busy tied low → tx_start, then after ACK_TIMEOUT cycles timeout_err=1 and the scheduler proceeds to the next byte or packet; timeout_err stays 1 until reset.
- Reset mid-operation: assert reset during WAIT_DONE → next cycle all outputs at reset values; after release, arbitration restarts at req 0.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and transmitter handshake bundle for uart_tx_scheduler
interface uart_tx_scheduler_if;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [2:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        timeout_err;

    // master is the environment: byte sources plus the uart_tx datapath
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_data, tx_start, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_data, tx_start, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin packet scheduler sharing one UART transmitter among three byte streams
module uart_tx_scheduler #(
    parameter int MAX_BURST   = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_scheduler_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t      state;
    logic [2:0]  grant_q;
    logic [1:0]  gidx;
    logic [1:0]  ptr;
    logic [3:0]  burst;
    logic [7:0]  ack_cnt;
    logic        last_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        timeout_err_q;

    logic [1:0]  winner;
    logic        any_valid;
    logic        xfer;
    logic        release_idle;
    logic [1:0]  next_ptr;
    logic [7:0]  sel_byte;
    logic        sel_last;

    // First requesting index at or after the pointer, wrapping 2 -> 0.
    always_comb begin
        logic [2:0] cand;
        logic       found;
        winner    = ptr;
        found     = 1'b0;
        cand      = 3'd0;
        any_valid = |bus.req_valid;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!found && bus.req_valid[cand[1:0]]) begin
                winner = cand[1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_byte     = bus.req_data[{gidx, 3'b000} +: 8];
        sel_last     = bus.req_last[gidx];
        xfer         = (state == LOAD) && (|(bus.req_valid & grant_q));
        release_idle = last_q || (burst == 4'(MAX_BURST));
        next_ptr     = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    end

    // Accept strobe is only ever offered to the owner, and only while loading.
    assign bus.req_ready   = (state == LOAD) ? (bus.req_valid & grant_q) : 3'b000;
    assign bus.grant       = grant_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.timeout_err = timeout_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grant_q       <= 3'b000;
            gidx          <= 2'd0;
            ptr           <= 2'd0;
            burst         <= 4'd0;
            ack_cnt       <= 8'd0;
            last_q        <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_q <= 3'b001 << winner;
                        gidx    <= winner;
                        burst   <= 4'd0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        tx_data_q  <= sel_byte;
                        last_q     <= sel_last;
                        burst      <= burst + 4'd1;
                        tx_start_q <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    tx_start_q <= 1'b0;
                    ack_cnt    <= 8'd0;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: flag it and move on as if sent.
                        timeout_err_q <= 1'b1;
                        if (release_idle) begin
                            grant_q <= 3'b000;
                            ptr     <= next_ptr;
                            state   <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (release_idle) begin
                            grant_q <= 3'b000;
                            ptr     <= next_ptr;
                            state   <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized bench for uart_tx_scheduler against a packet-level arbitration model
module tb_uart_tx_scheduler;

    localparam int MAX_BURST   = 4;
    localparam int ACK_TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_scheduler_if bus ();

    uart_tx_scheduler #(
        .MAX_BURST  (MAX_BURST),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Per-requester byte stores: bit 8 marks the last byte of a packet.
    logic [8:0] src_mem [3][64];
    int         src_len [3];
    int         src_head[3];

    logic [7:0] exp_data [256];
    logic [2:0] exp_grant[256];
    int         exp_n;

    int busy_cnt;
    bit busy_en;
    int busy_min, busy_max;
    int stall_pct;
    int lock_req;
    int lock_left;
    bit lock_used;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 3; i++) begin
            src_len[i]  = 0;
            src_head[i] = 0;
        end
        lock_req  = -1;
        lock_left = 0;
        lock_used = 1'b0;
        stall_pct = 0;
        busy_en   = 1'b1;
        busy_min  = 10;
        busy_max  = 10;
    endtask

    task automatic push(input int r, input logic [8:0] v);
        src_mem[r][src_len[r]] = v;
        src_len[r]++;
    endtask

    // Expected transmit order: round-robin over packets, at most MAX_BURST bytes per grant.
    task automatic build_model();
        int  h[3];
        int  ptr, g, cnt, idx;
        bit  last;
        for (int i = 0; i < 3; i++) h[i] = src_head[i];
        exp_n = 0;
        ptr   = 0;
        while (1) begin
            g = -1;
            for (int k = 0; k < 3; k++) begin
                idx = (ptr + k) % 3;
                if (g < 0 && h[idx] < src_len[idx]) g = idx;
            end
            if (g < 0) break;
            cnt = 0;
            last = 1'b0;
            while (!last && cnt < MAX_BURST && h[g] < src_len[g]) begin
                exp_data[exp_n]  = src_mem[g][h[g]][7:0];
                exp_grant[exp_n] = 3'b001 << g;
                last = src_mem[g][h[g]][8];
                h[g]++;
                exp_n++;
                cnt++;
            end
            ptr = (g + 1) % 3;
        end
    endtask

    function automatic bit drained();
        drained = 1'b1;
        for (int i = 0; i < 3; i++) if (src_head[i] != src_len[i]) drained = 1'b0;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 3; i++) begin
            bit has, stall;
            has   = src_head[i] < src_len[i];
            stall = (i == lock_req && lock_left > 0) ||
                    (bus.grant[i] && ($urandom_range(99) < stall_pct));
            bus.req_valid[i] = has && !stall;
            if (has) begin
                bus.req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
                bus.req_last[i]        = src_mem[i][src_head[i]][8];
            end else begin
                bus.req_data[8*i +: 8] = 8'h00;
                bus.req_last[i]        = 1'b0;
            end
        end
        bus.tx_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_grant", bus.grant, 3'b000);
        check_eq("rst_req_ready", bus.req_ready, 3'b000);
        check_eq("rst_tx_start", bus.tx_start, 1'b0);
        check_eq("rst_tx_data", bus.tx_data, 8'h00);
        check_eq("rst_timeout_err", bus.timeout_err, 1'b0);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = 3'b000;
        bus.req_data  = 24'h0;
        bus.req_last  = 3'b000;
        bus.tx_busy   = 1'b0;
        busy_cnt      = 0;
        clear_src();
        @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
    endtask

    task automatic run_scenario(input int abort_at);
        int         k, cyc, first_start, since_start;
        logic [2:0] xfer;
        logic [7:0] last_started;
        bit         done, aborted;
        k = 0; cyc = 0; first_start = -1; since_start = 0;
        last_started = 8'h00; done = 1'b0; aborted = 1'b0;
        lock_left = 0; lock_used = 1'b0;
        build_model();
        drive_inputs();
        #1;
        xfer = bus.req_valid & bus.req_ready;
        while (!done && !aborted && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            since_start++;
            for (int i = 0; i < 3; i++) if (xfer[i]) src_head[i]++;
            check_eq("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
            check_eq("ready_mask", bus.req_ready & ~(bus.req_valid & bus.grant), 3'b000);
            if (bus.tx_start) begin
                if (k < exp_n) begin
                    check_eq("tx_data_order", bus.tx_data, exp_data[k]);
                    check_eq("grant_at_start", bus.grant, exp_grant[k]);
                end else begin
                    check_eq("extra_tx_start", k, exp_n);
                end
                if (first_start < 0) first_start = cyc;
                last_started = bus.tx_data;
                since_start  = 0;
                k++;
                if (busy_en) busy_cnt = $urandom_range(busy_max, busy_min);
            end else if (bus.tx_busy) begin
                check_eq("tx_data_hold", bus.tx_data, last_started);
            end
            if (lock_left > 0) begin
                check_eq("lock_grant", bus.grant, 3'b001);
                check_eq("lock_no_start", bus.tx_start, 1'b0);
                lock_left--;
            end
            if (lock_req >= 0 && !lock_used && xfer[lock_req]) begin
                lock_left = 20;
                lock_used = 1'b1;
            end
            if (!busy_en && first_start >= 0) begin
                if (cyc == first_start + ACK_TIMEOUT - 1) check_eq("tmo_not_early", bus.timeout_err, 1'b0);
                if (cyc == first_start + ACK_TIMEOUT + 1) check_eq("tmo_set", bus.timeout_err, 1'b1);
            end
            if (abort_at > 0 && k >= abort_at && bus.tx_busy && since_start >= 3) begin
                reset         = 1'b1;
                bus.req_valid = 3'b000;
                bus.tx_busy   = 1'b0;
                busy_cnt      = 0;
                @(posedge clk);
                #1;
                check_reset_vals();
                reset   = 1'b0;
                aborted = 1'b1;
            end else if (k == exp_n && drained() && bus.grant == 3'b000) begin
                done = 1'b1;
            end else begin
                drive_inputs();
                #1;
                xfer = bus.req_valid & bus.req_ready;
            end
        end
        if (!aborted) begin
            check_eq("scenario_done", done, 1'b1);
            check_eq("bytes_sent", k, exp_n);
            check_eq("final_grant", bus.grant, 3'b000);
        end
    endtask

    initial begin
        int npk, len;
        reset = 1'b1;
        busy_cnt = 0;
        do_reset();

        // single requester, two-byte packet
        do_reset();
        push(1, 9'h048); push(1, 9'h169);
        run_scenario(0);

        // contention from reset
        do_reset();
        push(0, 9'h1A0); push(1, 9'h1B1); push(2, 9'h1C2);
        run_scenario(0);

        // burst limit forces rotation to requester 2
        do_reset();
        for (int b = 0; b < 6; b++) push(0, {b == 5, 8'h10 + 8'(b)});
        push(2, 9'h177);
        run_scenario(0);

        // packet lock while requester 0 stalls
        do_reset();
        push(0, 9'h055); push(0, 9'h156); push(1, 9'h1AA);
        lock_req = 0;
        run_scenario(0);

        // transmitter never acknowledges
        do_reset();
        busy_en = 1'b0;
        push(0, 9'h031); push(0, 9'h132); push(1, 9'h133);
        run_scenario(0);
        check_eq("tmo_sticky", bus.timeout_err, 1'b1);
        do_reset();

        // reset during a frame, then arbitration restarts at requester 0
        do_reset();
        push(0, 9'h001); push(0, 9'h002); push(0, 9'h103); push(1, 9'h0E0); push(1, 9'h1E1);
        run_scenario(2);
        clear_src();
        push(2, 9'h1C2); push(1, 9'h1B1); push(0, 9'h1A0);
        run_scenario(0);

        for (int n = 0; n < 24; n++) begin
            do_reset();
            busy_en   = (n % 5) != 4;
            busy_min  = 1;
            busy_max  = 12;
            stall_pct = (n % 2 == 1) ? 25 : 0;
            for (int r = 0; r < 3; r++) begin
                npk = $urandom_range(3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(6, 1);
                    for (int b = 0; b < len; b++) push(r, {b == len - 1, 8'($urandom)});
                end
            end
            run_scenario(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
